// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: dispenser state encoding and default coin values.
package vm_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSelect  = 3'd1,
    StReq     = 3'd2,
    StRelease = 3'd3,
    StDone    = 3'd4,
    StError   = 3'd5
  } disp_state_e;

  localparam int unsigned NumHoppers = 3;
  localparam int unsigned DefDenom2  = 10;
  localparam int unsigned DefDenom1  = 5;
  localparam int unsigned DefDenom0  = 1;

endpackage

// File: rtl/change_dispenser_if.sv
// Controller/hopper-facing signal bundle of the change dispenser.
interface change_dispenser_if #(
  parameter int unsigned AMT_W = 8
) ();

  logic             change_dispense_en;
  logic [AMT_W-1:0] change_amount;
  logic [2:0]       hopper_empty;
  logic             hopper_ack;
  logic             hopper_req;
  logic [1:0]       hopper_sel;
  logic             change_dispense_done;
  logic             change_error;
  logic [AMT_W-1:0] remaining_out;
  logic             busy;

  // Environment side: controller start plus hopper status/acknowledge.
  modport master (
    output change_dispense_en, change_amount, hopper_empty, hopper_ack,
    input  hopper_req, hopper_sel, change_dispense_done, change_error, remaining_out, busy
  );

  // Dispenser side.
  modport slave (
    input  change_dispense_en, change_amount, hopper_empty, hopper_ack,
    output hopper_req, hopper_sel, change_dispense_done, change_error, remaining_out, busy
  );

endinterface

// File: rtl/change_denom_select.sv
// Greedy coin pick: highest-value non-empty hopper whose coin still fits the amount owed.
module change_denom_select #(
  parameter int unsigned AMT_W  = 8,
  parameter int unsigned DENOM2 = 10,
  parameter int unsigned DENOM1 = 5,
  parameter int unsigned DENOM0 = 1
) (
  input  logic [AMT_W-1:0] i_remaining,
  input  logic [2:0]       i_hopper_empty,
  output logic [1:0]       o_sel,
  output logic             o_valid
);

  localparam logic [AMT_W-1:0] D2 = AMT_W'(DENOM2);
  localparam logic [AMT_W-1:0] D1 = AMT_W'(DENOM1);
  localparam logic [AMT_W-1:0] D0 = AMT_W'(DENOM0);

  logic w_fit2, w_fit1, w_fit0;

  assign w_fit2 = !i_hopper_empty[2] && (D2 <= i_remaining);
  assign w_fit1 = !i_hopper_empty[1] && (D1 <= i_remaining);
  assign w_fit0 = !i_hopper_empty[0] && (D0 <= i_remaining);

  // Priority encode from the largest denomination downwards.
  always_comb begin
    o_sel   = 2'd0;
    o_valid = 1'b0;
    if (w_fit2) begin
      o_sel   = 2'd2;
      o_valid = 1'b1;
    end else if (w_fit1) begin
      o_sel   = 2'd1;
      o_valid = 1'b1;
    end else if (w_fit0) begin
      o_sel   = 2'd0;
      o_valid = 1'b1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out an amount coin by coin over a four-phase hopper handshake.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int unsigned AMT_W       = 8,
  parameter int unsigned ACK_TIMEOUT = 64,
  parameter int unsigned DENOM2      = DefDenom2,
  parameter int unsigned DENOM1      = DefDenom1,
  parameter int unsigned DENOM0      = DefDenom0
) (
  input logic               clk,
  input logic               rst_n,
  change_dispenser_if.slave bus
);

  localparam int unsigned      WdW    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WdW-1:0]   WdLast = WdW'(ACK_TIMEOUT - 1);
  localparam logic [AMT_W-1:0] D2     = AMT_W'(DENOM2);
  localparam logic [AMT_W-1:0] D1     = AMT_W'(DENOM1);
  localparam logic [AMT_W-1:0] D0     = AMT_W'(DENOM0);

  disp_state_e      r_state, w_state_d;
  logic [1:0]       r_sel, w_sel_d;
  logic [AMT_W-1:0] r_rem, w_rem_d;
  logic             r_err, w_err_d;
  logic [WdW-1:0]   r_wdog, w_wdog_d;

  logic [1:0]       w_pick_sel;
  logic             w_pick_valid;
  logic [AMT_W-1:0] w_denom;

  change_denom_select #(
    .AMT_W  (AMT_W),
    .DENOM2 (DENOM2),
    .DENOM1 (DENOM1),
    .DENOM0 (DENOM0)
  ) u_denom_select (
    .i_remaining    (r_rem),
    .i_hopper_empty (bus.hopper_empty),
    .o_sel          (w_pick_sel),
    .o_valid        (w_pick_valid)
  );

  // Value of the coin currently being ejected.
  always_comb begin
    case (r_sel)
      2'd2:    w_denom = D2;
      2'd1:    w_denom = D1;
      default: w_denom = D0;
    endcase
  end

  // Next-state and datapath updates; the watchdog runs only in REQ/RELEASE.
  always_comb begin
    w_state_d = r_state;
    w_sel_d   = r_sel;
    w_rem_d   = r_rem;
    w_err_d   = r_err;
    w_wdog_d  = r_wdog;
    unique case (r_state)
      StIdle: begin
        if (bus.change_dispense_en) begin
          w_rem_d   = bus.change_amount;
          w_err_d   = 1'b0;
          w_state_d = StSelect;
        end
      end
      StSelect: begin
        if (r_rem == '0) begin
          w_state_d = StDone;
        end else if (w_pick_valid) begin
          w_sel_d   = w_pick_sel;
          w_wdog_d  = '0;
          w_state_d = StReq;
        end else begin
          w_state_d = StError;
        end
      end
      StReq: begin
        if (bus.hopper_ack) begin
          w_wdog_d  = '0;
          w_state_d = StRelease;
        end else if (r_wdog == WdLast) begin
          w_wdog_d  = '0;
          w_state_d = StError;
        end else begin
          w_wdog_d = r_wdog + WdW'(1);
        end
      end
      StRelease: begin
        if (!bus.hopper_ack) begin
          // SELECT only picks coins that fit, so this cannot underflow.
          w_rem_d   = r_rem - w_denom;
          w_wdog_d  = '0;
          w_state_d = StSelect;
        end else if (r_wdog == WdLast) begin
          w_wdog_d  = '0;
          w_state_d = StError;
        end else begin
          w_wdog_d = r_wdog + WdW'(1);
        end
      end
      StDone:  w_state_d = StIdle;
      StError: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    // Raise the error level on entry so it is valid alongside the done pulse.
    if (w_state_d == StError) begin
      w_err_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_sel   <= 2'd0;
      r_rem   <= '0;
      r_err   <= 1'b0;
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_d;
      r_sel   <= w_sel_d;
      r_rem   <= w_rem_d;
      r_err   <= w_err_d;
      r_wdog  <= w_wdog_d;
    end
  end

  assign bus.hopper_req           = (r_state == StReq);
  assign bus.hopper_sel           = r_sel;
  assign bus.change_dispense_done = (r_state == StDone) || (r_state == StError);
  assign bus.change_error         = r_err;
  assign bus.remaining_out        = r_rem;
  assign bus.busy                 = (r_state != StIdle);

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed table, hand sequences, random jobs.
module tb_change_dispenser;

  localparam int unsigned AmtW       = 8;
  localparam int unsigned AckTimeout = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  change_dispenser_if #(.AMT_W(AmtW)) bus ();

  change_dispenser #(
    .AMT_W       (AmtW),
    .ACK_TIMEOUT (AckTimeout),
    .DENOM2      (10),
    .DENOM1      (5),
    .DENOM0      (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int denom_of(input logic [1:0] sel);
    case (sel)
      2'd2:    return 10;
      2'd1:    return 5;
      2'd0:    return 1;
      default: return -1;
    endcase
  endfunction

  // Reference model: greedy change-making over the available coin values.
  int exp_coins[$];
  int exp_err, exp_rem, exp_timeout;

  task automatic model(input int amt, input logic [2:0] emp, input bit never);
    int denoms[3];
    int rem, pick;
    bit stop;
    denoms = '{1, 5, 10};
    exp_coins.delete();
    exp_err     = 0;
    exp_timeout = 0;
    rem         = amt;
    stop        = 0;
    while (rem > 0 && !stop) begin
      pick = -1;
      for (int h = 2; h >= 0; h--) begin
        if (pick < 0 && !emp[h] && denoms[h] <= rem) pick = h;
      end
      if (pick < 0) begin
        exp_err = 1;
        stop    = 1;
      end else if (never) begin
        exp_err     = 1;
        exp_timeout = 1;
        stop        = 1;
      end else begin
        exp_coins.push_back(denoms[pick]);
        rem -= denoms[pick];
      end
    end
    exp_rem = rem;
  endtask

  // Observed job results.
  int got_coins[$];
  int got_done, got_err, got_rem, got_done_at, got_req_cycles, got_busy_after;

  // Runs one job, acting as the hopper: ack `dly` cycles into a request (never if `never`),
  // drop ack once the request drops. A second start is poked at cycle `poke_at` if nonzero.
  task automatic run_job(input int amt, input logic [2:0] emp, input int dly, input bit never,
                         input int poke_at);
    int cnt, tail;
    bit prev_hs, hs_now;
    logic [1:0] prev_sel;
    cnt = 0;
    tail = -1;
    prev_hs = 0;
    prev_sel = 2'd0;
    got_coins.delete();
    got_done = 0;
    got_err = -1;
    got_rem = -1;
    got_done_at = -1;
    got_req_cycles = 0;
    @(negedge clk);
    bus.change_amount      = AmtW'(amt);
    bus.hopper_empty       = emp;
    bus.hopper_ack         = 1'b0;
    bus.change_dispense_en = 1'b1;
    for (int i = 1; i <= 1500; i++) begin
      @(negedge clk);
      bus.change_dispense_en = (i == poke_at);
      if (i == poke_at) bus.change_amount = 8'd99;
      if (bus.change_dispense_done) begin
        got_done++;
        if (got_done == 1) begin
          got_err     = int'(bus.change_error);
          got_rem     = int'(bus.remaining_out);
          got_done_at = i;
          tail        = i + 3;
        end
      end
      if (bus.hopper_req) got_req_cycles++;
      hs_now = bus.hopper_req || bus.hopper_ack;
      if (prev_hs && hs_now) check("sel_stable", bus.hopper_sel, prev_sel);
      prev_hs  = hs_now;
      prev_sel = bus.hopper_sel;
      if (bus.hopper_ack) begin
        if (!bus.hopper_req) bus.hopper_ack = 1'b0;
      end else if (bus.hopper_req) begin
        cnt++;
        if (!never && cnt >= dly) begin
          bus.hopper_ack = 1'b1;
          got_coins.push_back(denom_of(bus.hopper_sel));
          cnt = 0;
        end
      end
      if (i == tail) break;
    end
    got_busy_after = int'(bus.busy);
  endtask

  task automatic compare_job(input string tag);
    check({tag, ".done_pulses"}, got_done, 1);
    check({tag, ".error"}, got_err, exp_err);
    check({tag, ".remaining"}, got_rem, exp_rem);
    check({tag, ".ncoins"}, got_coins.size(), exp_coins.size());
    for (int k = 0; k < exp_coins.size() && k < got_coins.size(); k++)
      check({tag, ".coin"}, got_coins[k], exp_coins[k]);
    check({tag, ".busy_after"}, got_busy_after, 0);
    if (exp_timeout != 0) check({tag, ".req_cycles"}, got_req_cycles, AckTimeout);
  endtask

  typedef struct {
    int         amt;
    logic [2:0] emp;
    int         dly;
    bit         never;
    int         poke;
    int         exp_err;
    int         exp_rem;
    int         exp_n;
    int         exp_done_at;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int nd;
    bus.change_dispense_en = 1'b0;
    bus.change_amount      = '0;
    bus.hopper_empty       = 3'b000;
    bus.hopper_ack         = 1'b0;

    // Reset state, checked before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    check("rst.req", bus.hopper_req, 0);
    check("rst.sel", bus.hopper_sel, 0);
    check("rst.done", bus.change_dispense_done, 0);
    check("rst.err", bus.change_error, 0);
    check("rst.rem", bus.remaining_out, 0);
    check("rst.busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    //                 amt  emp     dly never poke  err rem n  done_at
    vecs.push_back(vec_t'{17, 3'b000, 2, 0, 0,     0, 0, 4, -1});
    vecs.push_back(vec_t'{0,  3'b000, 2, 0, 0,     0, 0, 0, 2});
    vecs.push_back(vec_t'{10, 3'b100, 2, 0, 0,     0, 0, 2, -1});
    vecs.push_back(vec_t'{3,  3'b001, 2, 0, 0,     1, 3, 0, -1});
    vecs.push_back(vec_t'{5,  3'b000, 0, 1, 0,     1, 5, 0, -1});
    vecs.push_back(vec_t'{7,  3'b000, 1, 0, 0,     0, 0, 3, -1});
    vecs.push_back(vec_t'{9,  3'b010, 1, 0, 0,     0, 0, 9, -1});
    vecs.push_back(vec_t'{6,  3'b011, 1, 0, 0,     1, 6, 0, -1});
    vecs.push_back(vec_t'{12, 3'b001, 2, 0, 0,     1, 2, 1, -1});
    vecs.push_back(vec_t'{5,  3'b000, 3, 0, 3,     0, 0, 1, -1});

    foreach (vecs[v]) begin
      model(vecs[v].amt, vecs[v].emp, vecs[v].never);
      run_job(vecs[v].amt, vecs[v].emp, vecs[v].dly, vecs[v].never, vecs[v].poke);
      compare_job($sformatf("vec%0d", v));
      check($sformatf("vec%0d.tbl_err", v), got_err, vecs[v].exp_err);
      check($sformatf("vec%0d.tbl_rem", v), got_rem, vecs[v].exp_rem);
      check($sformatf("vec%0d.tbl_n", v), got_coins.size(), vecs[v].exp_n);
      if (vecs[v].exp_done_at >= 0) begin
        check($sformatf("vec%0d.done_at", v), got_done_at, vecs[v].exp_done_at);
        check($sformatf("vec%0d.no_req", v), got_req_cycles, 0);
      end
    end

    // Reset in the middle of a handshake.
    @(negedge clk);
    bus.change_amount      = 8'd7;
    bus.hopper_empty       = 3'b000;
    bus.change_dispense_en = 1'b1;
    @(negedge clk);
    bus.change_dispense_en = 1'b0;
    for (int i = 0; i < 10 && !bus.hopper_req; i++) @(negedge clk);
    check("midrst.req_before", bus.hopper_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.req", bus.hopper_req, 0);
    check("midrst.sel", bus.hopper_sel, 0);
    check("midrst.done", bus.change_dispense_done, 0);
    check("midrst.err", bus.change_error, 0);
    check("midrst.rem", bus.remaining_out, 0);
    check("midrst.busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.change_dispense_done) nd++;
    end
    check("midrst.no_done", nd, 0);
    model(7, 3'b000, 0);
    run_job(7, 3'b000, 2, 0, 0);
    compare_job("after_rst");

    // Random jobs against the reference model.
    for (int r = 0; r < 25; r++) begin
      int amt, dly;
      logic [2:0] emp;
      bit never;
      amt   = $urandom_range(0, 40);
      emp   = 3'($urandom_range(0, 7));
      dly   = $urandom_range(1, 4);
      never = ($urandom_range(0, 7) == 0);
      model(amt, emp, never);
      run_job(amt, emp, dly, never, 0);
      compare_job($sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
